// File: rtl/hazard_control_pkg.sv
// Shared constants and FSM encoding for the LEGv8 pipeline hazard control block.
package hazard_control_pkg;

  localparam int unsigned XZR = 31;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow pipeline slot: destination register, write flag and load flag.
module hazard_shadow_stage #(
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [REG_W-1:0] d_rd,
  input  logic             d_wr,
  input  logic             d_load,
  output logic [REG_W-1:0] rd,
  output logic             wr,
  output logic             load
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd   <= '0;
      wr   <= 1'b0;
      load <= 1'b0;
    end else if (clear) begin
      rd   <= '0;
      wr   <= 1'b0;
      load <= 1'b0;
    end else if (en) begin
      rd   <= d_rd;
      wr   <= d_wr;
      load <= d_load;
    end
  end

endmodule

// File: rtl/hazard_control.sv
// Load-use stall, branch flush and EX forwarding control for the five-stage LEGv8 pipeline.
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             branch_taken,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  state_e state_q, state_d;

  logic [REG_W-1:0] ex_rd, mem_rd, wb_rd;
  logic             ex_wr, mem_wr, wb_wr;
  logic             ex_ld, mem_ld, wb_ld;

  logic       ex_live, mem_live;
  logic       id_eff, branch_eff, load_use, ex_take;
  logic [1:0] fwd_a_d, fwd_b_d;

  assign ex_live  = ex_wr && (ex_rd != REG_W'(XZR));
  assign mem_live = mem_wr && (mem_rd != REG_W'(XZR));

  // In the recovery cycle decode holds a squashed slot and any branch is stale.
  assign id_eff     = id_valid && (state_q != StFlush);
  assign branch_eff = branch_taken && (state_q != StFlush) && !reset;

  assign load_use = id_eff && ex_live && ex_ld && !reset &&
                    ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));

  assign flush     = branch_eff;
  assign bubble_ex = load_use && !branch_eff;
  assign stall_if  = bubble_ex;
  assign stall_id  = bubble_ex;
  assign ex_take   = id_eff && !bubble_ex && !branch_eff;

  hazard_shadow_stage #(.REG_W(REG_W)) u_ex (
    .clk    (clk),
    .reset  (reset),
    .clear  (!ex_take),
    .en     (1'b1),
    .d_rd   (id_rd),
    .d_wr   (id_reg_write),
    .d_load (id_mem_read),
    .rd     (ex_rd),
    .wr     (ex_wr),
    .load   (ex_ld)
  );

  hazard_shadow_stage #(.REG_W(REG_W)) u_mem (
    .clk    (clk),
    .reset  (reset),
    .clear  (branch_eff),
    .en     (1'b1),
    .d_rd   (ex_rd),
    .d_wr   (ex_wr),
    .d_load (ex_ld),
    .rd     (mem_rd),
    .wr     (mem_wr),
    .load   (mem_ld)
  );

  hazard_shadow_stage #(.REG_W(REG_W)) u_wb (
    .clk    (clk),
    .reset  (reset),
    .clear  (1'b0),
    .en     (1'b1),
    .d_rd   (mem_rd),
    .d_wr   (mem_wr),
    .d_load (mem_ld),
    .rd     (wb_rd),
    .wr     (wb_wr),
    .load   (wb_ld)
  );

  // Current ex becomes MEM and current mem becomes WB when this instruction reaches EX.
  always_comb begin
    fwd_a_d = FWD_REG;
    fwd_b_d = FWD_REG;
    if (ex_take) begin
      if (id_uses_rn && ex_live && (id_rn == ex_rd)) begin
        fwd_a_d = FWD_MEM;
      end else if (id_uses_rn && mem_live && (id_rn == mem_rd)) begin
        fwd_a_d = FWD_WB;
      end
      if (id_uses_rm && ex_live && (id_rm == ex_rd)) begin
        fwd_b_d = FWD_MEM;
      end else if (id_uses_rm && mem_live && (id_rm == mem_rd)) begin
        fwd_b_d = FWD_WB;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (branch_eff) state_d = StFlush;
        else if (load_use) state_d = StStall;
      end
      StStall: state_d = branch_eff ? StFlush : StRun;
      StFlush: state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      fwd_a       <= FWD_REG;
      fwd_b       <= FWD_REG;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state_q <= state_d;
      fwd_a   <= fwd_a_d;
      fwd_b   <= fwd_b_d;
      if (bubble_ex && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule
